// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: soft-start/soft-stop speed sequencer for the PWM generator.
// Ports: clock, reset (sync, high), run_req, target[2:0], estop -> speed_out[2:0], pwm_en, ramping, at_target, fault.
module pwm_ramp_ctrl #(
  parameter int unsigned STEP_CYCLES = 1000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run_req,
  input  logic [2:0] target,
  input  logic       estop,
  output logic [2:0] speed_out,
  output logic       pwm_en,
  output logic       ramping,
  output logic       at_target,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(STEP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]       speed_q, speed_d;
  logic [2:0]       ramp_spd, drain_spd;
  logic             fault_q, fault_d;
  logic             tick;

  assign tick    = (cnt_q == TICK_AT);
  assign cnt_inc = tick ? '0 : cnt_q + CNT_W'(1);

  // target is 0..7, so stepping toward it can never leave 0..7
  always_comb begin
    ramp_spd = speed_q;
    if (target > speed_q)
      ramp_spd = speed_q + 3'd1;
    else if (target < speed_q)
      ramp_spd = speed_q - 3'd1;
  end

  assign drain_spd = (speed_q == 3'd0) ? 3'd0 : speed_q - 3'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    speed_d = speed_q;
    fault_d = fault_q;
    if (estop) begin
      state_d = IDLE;
      cnt_d   = '0;
      speed_d = 3'd0;
      fault_d = 1'b1;
    end else begin
      if (fault_q && !run_req)
        fault_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          speed_d = 3'd0;
          if (run_req && !fault_q)
            state_d = (target != 3'd0) ? RAMP : HOLD;
        end
        RAMP: begin
          cnt_d = cnt_inc;
          if (tick) begin
            speed_d = ramp_spd;
            if (ramp_spd == target) begin
              state_d = HOLD;
              cnt_d   = '0;
            end
          end
          // a dropped request beats reaching target; the step still lands
          if (!run_req) begin
            state_d = DRAIN;
            cnt_d   = cnt_inc;
          end
        end
        HOLD: begin
          cnt_d = '0;
          if (!run_req)
            state_d = (speed_q != 3'd0) ? DRAIN : IDLE;
          else if (target != speed_q)
            state_d = RAMP;
        end
        DRAIN: begin
          cnt_d = cnt_inc;
          if (run_req) begin
            state_d = RAMP;
          end else if (tick) begin
            speed_d = drain_spd;
            if (drain_spd == 3'd0) begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          speed_d = 3'd0;
        end
      endcase
    end
  end

  // status flags are registered from the next state so they
  // change on the same edge as the state itself
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      speed_q   <= 3'd0;
      fault_q   <= 1'b0;
      pwm_en    <= 1'b0;
      ramping   <= 1'b0;
      at_target <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      speed_q   <= speed_d;
      fault_q   <= fault_d;
      pwm_en    <= (state_d != IDLE);
      ramping   <= (state_d == RAMP) || (state_d == DRAIN);
      at_target <= (state_d == HOLD);
    end
  end

  assign speed_out = speed_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: vector table plus scoreboard for pwm_ramp_ctrl.
// STEP_CYCLES=4; each vector holds inputs for n edges then checks outputs.
module tb_pwm_ramp_ctrl;

  logic       clock;
  logic       reset;
  logic       run_req;
  logic [2:0] target;
  logic       estop;
  logic [2:0] speed_out;
  logic       pwm_en;
  logic       ramping;
  logic       at_target;
  logic       fault;

  int checks = 0;
  int errors = 0;

  pwm_ramp_ctrl #(
    .STEP_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .run_req(run_req),
    .target(target),
    .estop(estop),
    .speed_out(speed_out),
    .pwm_en(pwm_en),
    .ramping(ramping),
    .at_target(at_target),
    .fault(fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic       rst;
    logic       run;
    logic [2:0] tgt;
    logic       es;
    int         n;
    logic [6:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [6:0] sb[$];

  function automatic vec_t mk(
    input string nm, input logic rs, input logic rn,
    input logic [2:0] tg, input logic e, input int n,
    input logic [2:0] spd, input logic en, input logic rmp,
    input logic at, input logic fl
  );
    vec_t v;
    v.name = nm;
    v.rst  = rs;
    v.run  = rn;
    v.tgt  = tg;
    v.es   = e;
    v.n    = n;
    v.exp  = {spd, en, rmp, at, fl};
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic [6:0] got;
    logic [6:0] exp;
    reset   = v.rst;
    run_req = v.run;
    target  = v.tgt;
    estop   = v.es;
    sb.push_back(v.exp);
    repeat (v.n) @(posedge clock);
    @(negedge clock);
    got = {speed_out, pwm_en, ramping, at_target, fault};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", v.name);
    end else begin
      exp = sb.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s got spd=%0d en=%b rmp=%b at=%b flt=%b exp spd=%0d en=%b rmp=%b at=%b flt=%b",
                 v.name, got[6:4], got[3], got[2], got[1], got[0],
                 exp[6:4], exp[3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    run_req = 1'b0;
    target  = 3'd0;
    estop   = 1'b0;
    @(negedge clock);

    //                name      rst run tgt es n   spd en rmp at flt
    tbl.push_back(mk("reset",     1, 0, 0, 0, 2,  0, 0, 0, 0, 0));
    tbl.push_back(mk("start_c1",  0, 1, 5, 0, 1,  0, 1, 1, 0, 0));
    tbl.push_back(mk("start_c4",  0, 1, 5, 0, 3,  0, 1, 1, 0, 0));
    tbl.push_back(mk("start_c5",  0, 1, 5, 0, 1,  1, 1, 1, 0, 0));
    tbl.push_back(mk("start_c9",  0, 1, 5, 0, 4,  2, 1, 1, 0, 0));
    tbl.push_back(mk("start_c13", 0, 1, 5, 0, 4,  3, 1, 1, 0, 0));
    tbl.push_back(mk("start_c16", 0, 1, 5, 0, 3,  3, 1, 1, 0, 0));
    tbl.push_back(mk("start_c17", 0, 1, 5, 0, 1,  4, 1, 1, 0, 0));
    tbl.push_back(mk("start_c21", 0, 1, 5, 0, 4,  5, 1, 0, 1, 0));
    tbl.push_back(mk("hold5",     0, 1, 5, 0, 5,  5, 1, 0, 1, 0));
    tbl.push_back(mk("stop_d0",   0, 0, 5, 0, 1,  5, 1, 1, 0, 0));
    tbl.push_back(mk("stop_d3",   0, 0, 5, 0, 3,  5, 1, 1, 0, 0));
    tbl.push_back(mk("stop_d4",   0, 0, 5, 0, 1,  4, 1, 1, 0, 0));
    tbl.push_back(mk("stop_d19",  0, 0, 5, 0, 15, 1, 1, 1, 0, 0));
    tbl.push_back(mk("stop_d20",  0, 0, 5, 0, 1,  0, 0, 0, 0, 0));
    tbl.push_back(mk("stop_idle", 0, 0, 5, 0, 3,  0, 0, 0, 0, 0));
    tbl.push_back(mk("zero_hold", 0, 1, 0, 0, 1,  0, 1, 0, 1, 0));
    tbl.push_back(mk("zero_stay", 0, 1, 0, 0, 3,  0, 1, 0, 1, 0));
    tbl.push_back(mk("zero_off",  0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
    tbl.push_back(mk("rt_enter",  0, 1, 6, 0, 1,  0, 1, 1, 0, 0));
    tbl.push_back(mk("rt_at3",    0, 1, 6, 0, 12, 3, 1, 1, 0, 0));
    tbl.push_back(mk("rt_no_ovs", 0, 1, 1, 0, 3,  3, 1, 1, 0, 0));
    tbl.push_back(mk("rt_to2",    0, 1, 1, 0, 1,  2, 1, 1, 0, 0));
    tbl.push_back(mk("rt_to1",    0, 1, 1, 0, 4,  1, 1, 0, 1, 0));
    tbl.push_back(mk("rt_hold1",  0, 1, 1, 0, 8,  1, 1, 0, 1, 0));
    tbl.push_back(mk("es_ramp",   0, 1, 4, 0, 1,  1, 1, 1, 0, 0));
    tbl.push_back(mk("es_hold4",  0, 1, 4, 0, 12, 4, 1, 0, 1, 0));
    tbl.push_back(mk("es_hit",    0, 1, 4, 1, 1,  0, 0, 0, 0, 1));
    tbl.push_back(mk("es_locked", 0, 1, 4, 0, 5,  0, 0, 0, 0, 1));
    tbl.push_back(mk("es_clear",  0, 0, 4, 0, 1,  0, 0, 0, 0, 0));
    tbl.push_back(mk("es_restrt", 0, 1, 2, 0, 1,  0, 1, 1, 0, 0));
    tbl.push_back(mk("es_step1",  0, 1, 2, 0, 4,  1, 1, 1, 0, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // reset in the middle of a drain, then a fresh request
    apply(mk("rd_reset",  1, 0, 0, 0, 1,  0, 0, 0, 0, 0));
    apply(mk("rd_ramp3",  0, 1, 4, 0, 13, 3, 1, 1, 0, 0));
    apply(mk("rd_drain",  0, 0, 4, 0, 1,  3, 1, 1, 0, 0));
    apply(mk("rd_rst",    1, 0, 4, 0, 1,  0, 0, 0, 0, 0));
    apply(mk("rd_req",    0, 1, 2, 0, 1,  0, 1, 1, 0, 0));
    apply(mk("rd_wait",   0, 1, 2, 0, 3,  0, 1, 1, 0, 0));
    apply(mk("rd_step",   0, 1, 2, 0, 1,  1, 1, 1, 0, 0));

    // request drops on the edge of the final up-step
    apply(mk("sf_reset",  1, 0, 0, 0, 1,  0, 0, 0, 0, 0));
    apply(mk("sf_ramp",   0, 1, 1, 0, 4,  0, 1, 1, 0, 0));
    apply(mk("sf_fall",   0, 0, 1, 0, 1,  1, 1, 1, 0, 0));
    apply(mk("sf_drain",  0, 0, 1, 0, 3,  1, 1, 1, 0, 0));
    apply(mk("sf_idle",   0, 0, 1, 0, 1,  0, 0, 0, 0, 0));

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d left exp 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
